ptos_tx: RTL and testbench

Parallel-to-serial transmitter for the SPI datapath. It is the transmit counterpart of the existing serial-to-parallel receiver. A width-bit word is accepted through a valid/ready handshake and shifted out MSB first, one bit per enabled clock. The receiver samples the same enabled clock edge, so the two blocks connect directly: out -> in, enable shared. A one-entry holding buffer allows back-to-back words with no idle bit between them.

---
 rtl/ptos_tx.sv | 90 +++++++++
 tb/tb_ptos_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ptos_tx.sv
// Parallel-to-serial SPI transmitter: valid/ready word in, MSB-first bit stream out,
// one bit per enabled clock, with a one-word holding buffer for gapless back-to-back words.
module ptos_tx #(
  parameter int   width      = 10,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] data_in,
  input  logic             load,
  output logic             ready,
  input  logic             enable,
  output logic             out,
  output logic             busy,
  output logic             finish
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0] CNT_MAX = CW'(width - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q;
  logic [width-1:0]   shreg_q;
  logic [width-1:0]   hold_q;
  logic [CW-1:0]      cnt_q;
  logic               hold_vld_q;
  logic               finish_q;

  logic               accept;
  logic               last_bit;
  logic [width-1:0]   shreg_d;

  assign ready    = !hold_vld_q;
  assign accept   = load && ready;
  assign last_bit = (state_q == SHIFT) && enable && (cnt_q == '0);
  assign shreg_d  = {shreg_q[width-2:0], 1'b0};

  assign out    = (state_q == SHIFT) ? shreg_q[width-1] : IDLE_LEVEL;
  assign busy   = (state_q == SHIFT);
  assign finish = finish_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      hold_vld_q <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q <= data_in;
            cnt_q   <= CNT_MAX;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable) begin
            if (cnt_q != '0) begin
              shreg_q <= shreg_d;
              cnt_q   <= cnt_q - 1'b1;
            end else begin
              // Last bit consumed: chain the next word without an idle bit if one exists.
              finish_q <= 1'b1;
              if (hold_vld_q) begin
                shreg_q    <= hold_q;
                hold_vld_q <= 1'b0;
                cnt_q      <= CNT_MAX;
              end else if (accept) begin
                shreg_q <= data_in;
                cnt_q   <= CNT_MAX;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          if (accept && !last_bit) begin
            hold_q     <= data_in;
            hold_vld_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptos_tx.sv
// Directed bench for ptos_tx (width=10): a serial receiver monitor rebuilds words from
// out/enable and each scenario task compares against hand-computed values.
module tb_ptos_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] data_in = '0;
  logic       load = 1'b0;
  logic       ready;
  logic       enable = 1'b0;
  logic       out;
  logic       busy;
  logic       finish;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] rxq[$];
  logic [9:0] rx_sh;
  int         rx_cnt;

  ptos_tx #(.width(10), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .ready(ready),
    .enable(enable), .out(out), .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

  // Receiver samples out on the same enabled edge that the transmitter consumes a bit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt <= 0;
    end else if (enable && busy) begin
      rx_sh <= {rx_sh[8:0], out};
      if (rx_cnt == 9) begin
        rxq.push_back({rx_sh[8:0], out});
        rx_cnt <= 0;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if ({out, busy, ready, finish} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_state: out/busy/ready/finish=%b required 0010", {out, busy, ready, finish});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [9:0] w = 10'h2C5;
    rxq.delete();
    data_in = w; load = 1'b1; enable = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (out !== w[9-i] || busy !== 1'b1 || finish !== 1'b0) begin
        n_fail++;
        $display("FAIL single_bit%0d: out=%b busy=%b finish=%b required out=%b busy=1 finish=0",
                 i, out, busy, finish, w[9-i]);
      end
      tick();
    end
    n_tests++;
    if (finish !== 1'b1 || busy !== 1'b0 || out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: finish=%b busy=%b out=%b required 1 0 0", finish, busy, out);
    end
    n_tests++;
    if (rxq.size() != 1 || rxq[0] !== 10'h2C5) begin
      n_fail++;
      $display("FAIL single_rx: size=%0d word=%h required 1 word 2c5", rxq.size(), (rxq.size() > 0) ? rxq[0] : 10'h0);
    end
    tick();
    n_tests++;
    if (finish !== 1'b0) begin
      n_fail++;
      $display("FAIL single_finish_pulse: finish=%b required 0", finish);
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_gaps();
    int  en_cnt = 0;
    bit  got_fin = 0;
    logic prev;
    rxq.delete();
    data_in = 10'h2C5; load = 1'b1; enable = 1'b0;
    tick();
    load = 1'b0;
    for (int c = 0; c < 100 && !got_fin; c++) begin
      enable = (c % 3 == 0);
      prev = out;
      tick();
      if (enable) en_cnt++;
      else begin
        n_tests++;
        if (out !== prev) begin
          n_fail++;
          $display("FAIL gaps_hold_c%0d: out=%b required %b", c, out, prev);
        end
      end
      if (finish) got_fin = 1;
    end
    n_tests++;
    if (!got_fin || en_cnt != 10) begin
      n_fail++;
      $display("FAIL gaps_count: finish_seen=%0d enabled_edges=%0d required 1 and 10", got_fin, en_cnt);
    end
    n_tests++;
    if (rxq.size() != 1 || rxq[0] !== 10'h2C5) begin
      n_fail++;
      $display("FAIL gaps_rx: size=%0d word=%h required 1 word 2c5", rxq.size(), (rxq.size() > 0) ? rxq[0] : 10'h0);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    rxq.delete();
    data_in = 10'h3FF; load = 1'b1; enable = 1'b1;
    tick();
    load = 1'b0;
    tick();
    data_in = 10'h000; load = 1'b1;
    tick();
    load = 1'b0;
    for (int j = 2; j <= 21; j++) begin
      n_tests++;
      if (out !== (j <= 9) || ready !== (j >= 10) || finish !== (j == 10 || j == 20) || busy !== (j < 20)) begin
        n_fail++;
        $display("FAIL b2b_e%0d: out=%b ready=%b finish=%b busy=%b required %b %b %b %b", j, out, ready, finish, busy,
                 (j <= 9), (j >= 10), (j == 10 || j == 20), (j < 20));
      end
      tick();
    end
    n_tests++;
    if (rxq.size() != 2 || rxq[0] !== 10'h3FF || rxq[1] !== 10'h000) begin
      n_fail++;
      $display("FAIL b2b_rx: size=%0d required 2 words 3ff,000", rxq.size());
    end
    enable = 1'b0;
  endtask

  task automatic test_bypass();
    logic [9:0] w1 = 10'h155;
    logic [9:0] w2 = 10'h0F0;
    logic       eo;
    rxq.delete();
    data_in = w1; load = 1'b1; enable = 1'b1;
    tick();
    load = 1'b0;
    for (int j = 0; j <= 21; j++) begin
      eo = (j <= 9) ? w1[9-j] : (j <= 19) ? w2[19-j] : 1'b0;
      n_tests++;
      if (out !== eo || ready !== 1'b1 || finish !== (j == 10 || j == 20) || busy !== (j < 20)) begin
        n_fail++;
        $display("FAIL bypass_e%0d: out=%b ready=%b finish=%b busy=%b required %b 1 %b %b", j, out, ready, finish, busy,
                 eo, (j == 10 || j == 20), (j < 20));
      end
      if (j == 9) begin
        data_in = w2; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (rxq.size() != 2 || rxq[0] !== 10'h155 || rxq[1] !== 10'h0F0) begin
      n_fail++;
      $display("FAIL bypass_rx: size=%0d required 2 words 155,0f0", rxq.size());
    end
    enable = 1'b0;
  endtask

  task automatic test_load_full();
    rxq.delete();
    data_in = 10'h3C3; load = 1'b1; enable = 1'b1;
    tick();
    load = 1'b0;
    tick();
    data_in = 10'h0A5; load = 1'b1;
    tick();
    data_in = 10'h123;
    for (int j = 3; j <= 8; j++) begin
      n_tests++;
      if (ready !== 1'b0) begin
        n_fail++;
        $display("FAIL full_ready_e%0d: ready=%b required 0", j, ready);
      end
      tick();
    end
    load = 1'b0;
    for (int j = 0; j < 20; j++) tick();
    n_tests++;
    if (rxq.size() != 2 || rxq[0] !== 10'h3C3 || rxq[1] !== 10'h0A5 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_rx: size=%0d busy=%b required 2 words 3c3,0a5 and busy 0", rxq.size(), busy);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    int fin_cnt = 0;
    data_in = 10'h2AA; load = 1'b1; enable = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out, busy, ready, finish} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_mid_state: out/busy/ready/finish=%b required 0010", {out, busy, ready, finish});
    end
    #1 rst_n = 1'b1;
    tick();
    rxq.delete();
    data_in = 10'h001; load = 1'b1;
    tick();
    load = 1'b0;
    for (int j = 0; j < 14; j++) begin
      tick();
      if (finish) fin_cnt++;
    end
    n_tests++;
    if (fin_cnt != 1 || rxq.size() != 1 || rxq[0] !== 10'h001) begin
      n_fail++;
      $display("FAIL reset_mid_rx: finishes=%0d size=%0d required 1 finish and word 001", fin_cnt, rxq.size());
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_enable_gaps();
    test_back_to_back();
    test_bypass();
    test_load_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
